// File: rtl/analogizer_pad_pkg.sv
// Shared constants for the Analogizer SNAC pad mapper: map-mode encoding,
// face-button indices, raw/output bit positions and the per-mode remap.
package analogizer_pad_pkg;

    localparam int PAD_W    = 16;
    localparam int NUM_FACE = 4;

    // Map-mode encoding (i_map_mode / active mode)
    localparam logic [1:0] MAP_MODE_SWAP = 2'd0;  // face buttons reversed, select/start moved
    localparam logic [1:0] MAP_MODE_PASS = 2'd1;  // raw word straight through
    localparam logic [1:0] MAP_MODE_KEEP = 2'd2;  // like SWAP but face buttons in raw order
    localparam logic [1:0] MAP_MODE_RSVD = 2'd3;  // behaves as SWAP

    // Face-button indices in the mapped output word
    localparam int FACE_A = 0;
    localparam int FACE_B = 1;
    localparam int FACE_C = 2;
    localparam int FACE_D = 3;

    // Output bit positions
    localparam int OUT_DPAD_LO  = 4;
    localparam int OUT_DPAD_HI  = 7;
    localparam int OUT_SEL_BIT  = 8;
    localparam int OUT_STRT_BIT = 9;

    // Raw SNAC bit positions that move
    localparam int RAW_SEL_BIT  = 15;
    localparam int RAW_STRT_BIT = 14;

    // Remap one player's stable raw word into the core's button layout.
    function automatic logic [PAD_W-1:0] map_word(input logic [1:0] mode,
                                                  input logic [PAD_W-1:0] b);
        logic [PAD_W-1:0] w;
        w = '0;
        case (mode)
            MAP_MODE_PASS: begin
                w = b;
            end
            MAP_MODE_KEEP: begin
                w[FACE_D:FACE_A]             = b[3:0];
                w[OUT_DPAD_HI:OUT_DPAD_LO]   = b[7:4];
                w[OUT_SEL_BIT]               = b[RAW_SEL_BIT];
                w[OUT_STRT_BIT]              = b[RAW_STRT_BIT];
            end
            default: begin
                // MAP_MODE_SWAP and MAP_MODE_RSVD share the default layout
                w[FACE_A]                    = b[3];
                w[FACE_B]                    = b[2];
                w[FACE_C]                    = b[1];
                w[FACE_D]                    = b[0];
                w[OUT_DPAD_HI:OUT_DPAD_LO]   = b[7:4];
                w[OUT_SEL_BIT]               = b[RAW_SEL_BIT];
                w[OUT_STRT_BIT]              = b[RAW_STRT_BIT];
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/analogizer_pad_debounce.sv
// 16-bit strobe-sampled debouncer for one SNAC player. A bit's stable value
// follows raw only after DEBOUNCE_CNT consecutive strobed samples that differ
// from it; any agreeing sample restarts the count. o_update pulses in the
// cycle the new stable word becomes visible.
module analogizer_pad_debounce
    import analogizer_pad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PAD_W-1:0] i_raw,
    input  logic             i_stb,
    output logic [PAD_W-1:0] o_stable,
    output logic             o_update
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CNT - 1);

    logic [3:0]       cnt_q [PAD_W];
    logic [3:0]       cnt_d [PAD_W];
    logic [PAD_W-1:0] stable_q, stable_d;
    logic             update_q, update_d;

    // Per-bit counter and acceptance, evaluated only on strobed cycles
    always_comb begin
        stable_d = stable_q;
        update_d = 1'b0;
        for (int i = 0; i < PAD_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_stb) begin
                if (i_raw[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = i_raw[i];
                    cnt_d[i]    = '0;
                    update_d    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PAD_W; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            update_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            update_q <= update_d;
        end
    end

    assign o_stable = stable_q;
    assign o_update = update_q;

endmodule

// File: rtl/analogizer_pad_mapper.sv
// Analogizer SNAC pad mapper: debounces each player's raw button word, remaps
// it into the core layout selected by a frame-synchronous map mode, applies
// per-button turbo gating from a frame-counted phase, and registers the
// result. o_valid pulses exactly once per o_player rewrite.
//
// Handshake: o_valid is a one-cycle pulse coincident with the cycle the new
// o_player value first appears; there is no ready, the consumer must take it.
module analogizer_pad_mapper
    import analogizer_pad_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int DEBOUNCE_CNT = 4,
    parameter int TURBO_DIV    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_PLAYERS*16-1:0]   i_btn_raw,
    input  logic                        i_btn_stb,
    input  logic                        i_vsync,
    input  logic [1:0]                  i_map_mode,
    input  logic [NUM_PLAYERS*4-1:0]    i_turbo_en,
    output logic [NUM_PLAYERS*16-1:0]   o_player,
    output logic                        o_valid
);

    localparam logic [3:0] FRAME_LAST = 4'(TURBO_DIV - 1);

    logic [NUM_PLAYERS*16-1:0] stable;
    logic [NUM_PLAYERS-1:0]    stable_upd;

    logic       vsync_q, vsync_d;
    logic       hist_q, hist_d;      // vsync history holds a real sample
    logic       tick_q, tick_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic       phase_q, phase_d;
    logic       frame_tick;

    logic [NUM_PLAYERS*16-1:0] mapped;
    logic [PAD_W-1:0]          word;
    logic                      rewrite;
    logic [NUM_PLAYERS*16-1:0] player_q, player_d;
    logic                      valid_q, valid_d;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        analogizer_pad_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_debounce (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_btn_raw[p*16 +: 16]),
            .i_stb    (i_btn_stb),
            .o_stable (stable[p*16 +: 16]),
            .o_update (stable_upd[p])
        );
    end

    // Frame tick, frame-synchronous mode latch and turbo phase counter.
    // The history-valid flag keeps a vsync already high out of reset from
    // being seen as a rising edge.
    always_comb begin
        frame_tick  = hist_q & i_vsync & ~vsync_q;
        vsync_d     = i_vsync;
        hist_d      = 1'b1;
        tick_d      = frame_tick;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_tick) begin
            mode_d = i_map_mode;
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 4'd1;
            end
        end
    end

    // Remap each player and gate turbo-enabled face buttons with the phase
    always_comb begin
        mapped = '0;
        word   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            word = map_word(mode_q, stable[p*16 +: 16]);
            for (int k = 0; k < NUM_FACE; k++) begin
                if (i_turbo_en[p*4 + k]) begin
                    word[k] = word[k] & phase_q;
                end
            end
            mapped[p*16 +: 16] = word;
        end
    end

    // Rewrite the output once when either debounced state or frame state moved
    always_comb begin
        rewrite  = (|stable_upd) | tick_q;
        player_d = rewrite ? mapped : player_q;
        valid_d  = rewrite;
    end

    // Frame and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vsync_q     <= 1'b0;
            hist_q      <= 1'b0;
            tick_q      <= 1'b0;
            mode_q      <= MAP_MODE_SWAP;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            player_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            hist_q      <= hist_d;
            tick_q      <= tick_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            player_q    <= player_d;
            valid_q     <= valid_d;
        end
    end

    assign o_player = player_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_analogizer_pad_mapper.sv
// Directed bench for analogizer_pad_mapper (2 players, DEBOUNCE_CNT=4,
// TURBO_DIV=2). Expected o_player words are queued as stimulus is issued; a
// negedge monitor pops one per o_valid pulse.
module tb_analogizer_pad_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] btn_raw;
  logic        btn_stb;
  logic        vsync;
  logic [1:0]  map_mode;
  logic [7:0]  turbo_en;
  logic [31:0] o_player;
  logic        o_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] turbo_exp [6];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  analogizer_pad_mapper #(
    .NUM_PLAYERS  (2),
    .DEBOUNCE_CNT (4),
    .TURBO_DIV    (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_raw  (btn_raw),
    .i_btn_stb  (btn_stb),
    .i_vsync    (vsync),
    .i_map_mode (map_mode),
    .i_turbo_en (turbo_en),
    .o_player   (o_player),
    .o_valid    (o_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_player %h expected no pulse", o_player);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", o_player, mon_exp);
      end
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] p0, input logic [15:0] p1);
    btn_raw = {p1, p0};
    btn_stb = 1'b1;
    @(posedge clk);
    #1;
    btn_stb = 1'b0;
  endtask

  task automatic strobe_n(input int n, input logic [15:0] p0, input logic [15:0] p1);
    repeat (n) begin
      strobe(p0, p1);
      idle(1);
    end
  endtask

  initial begin
    rst = 1'b1; btn_raw = '0; btn_stb = 1'b0; vsync = 1'b0;
    map_mode = 2'd0; turbo_en = '0;
    turbo_exp[0] = 32'h0; turbo_exp[1] = 32'h1; turbo_exp[2] = 32'h1;
    turbo_exp[3] = 32'h0; turbo_exp[4] = 32'h0; turbo_exp[5] = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_player", o_player, 32'h0);
    check("reset_valid", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;

    // 4 strobes of 0x0001 on p0 -> mode 0 maps b0 to out[3]; latency 2
    strobe_n(3, 16'h0001, 16'h0000);
    exp_q.push_back(32'h0000_0008);
    strobe(16'h0001, 16'h0000);
    #4;
    check("latency_n1", o_player, 32'h0);
    @(negedge clk);
    check("latency_n2_player", o_player, 32'h0000_0008);
    check("latency_n2_valid", {31'b0, o_valid}, 32'h1);
    @(negedge clk);
    check("single_valid", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;

    // p1: 3 differing strobes then an agreeing one, twice -> never accepted
    strobe_n(3, 16'h0001, 16'h0001);
    strobe_n(1, 16'h0001, 16'h0000);
    strobe_n(3, 16'h0001, 16'h0001);
    strobe_n(1, 16'h0001, 16'h0000);
    idle(3);
    check("glitch_reject", o_player, 32'h0000_0008);

    // stable 0xC00F in mode 0 -> 0x030F; mode 1 requested mid-frame
    strobe_n(3, 16'hC00F, 16'h0000);
    exp_q.push_back(32'h0000_030F);
    strobe(16'hC00F, 16'h0000);
    idle(4);
    map_mode = 2'd1;
    idle(6);
    check("mode_hold", o_player, 32'h0000_030F);
    exp_q.push_back(32'h0000_C00F);
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mode_latch_n1", o_player, 32'h0000_030F);
    @(negedge clk);
    check("mode_latch_n2", o_player, 32'h0000_C00F);
    @(posedge clk); #1;
    vsync = 1'b0;
    idle(3);

    // stable update and vsync rise in the same cycle, mode 2 requested
    map_mode = 2'd2;
    idle(3);
    strobe_n(3, 16'h8003, 16'h0000);
    exp_q.push_back(32'h0000_0103);
    vsync = 1'b1;
    strobe(16'h8003, 16'h0000);
    @(negedge clk);
    check("coincide_n1", o_player, 32'h0000_C00F);
    @(negedge clk);
    check("coincide_player", o_player, 32'h0000_0103);
    check("coincide_valid", {31'b0, o_valid}, 32'h1);
    @(negedge clk);
    check("coincide_single", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;
    vsync = 1'b0;
    idle(3);

    // stable 0x00F0 (mode 2 -> 0x00F0), then reset mid-debounce with vsync high
    strobe_n(3, 16'h00F0, 16'h0000);
    exp_q.push_back(32'h0000_00F0);
    strobe(16'h00F0, 16'h0000);
    idle(4);
    strobe_n(2, 16'h0000, 16'h0000);
    rst = 1'b1;
    vsync = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    map_mode = 2'd0;
    @(negedge clk);
    check("reset_mid_player", o_player, 32'h0);
    check("reset_mid_valid", {31'b0, o_valid}, 32'h0);
    @(posedge clk); #1;
    idle(3);
    strobe_n(3, 16'h00F0, 16'h0000);
    idle(3);
    check("reaccept_wait", o_player, 32'h0);
    exp_q.push_back(32'h0000_00F0);
    strobe(16'h00F0, 16'h0000);
    idle(4);
    check("reaccept_done", o_player, 32'h0000_00F0);
    vsync = 1'b0;
    idle(3);

    // turbo on A (raw b3 in mode 0), phase 0 after reset -> 0,0,1,1,0,0,1
    turbo_en = 8'h01;
    strobe_n(3, 16'h0008, 16'h0000);
    exp_q.push_back(32'h0000_0000);
    strobe(16'h0008, 16'h0000);
    idle(4);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(turbo_exp[i]);
      vsync = 1'b1;
      idle(3);
      vsync = 1'b0;
      idle(3);
    end

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
